// File: rtl/game_tick_sched_if.sv
// Handshake bundle between the game logic / clock divider and the tick scheduler.
// The master side drives the game events and clk_game; the slave side is the scheduler.
interface game_tick_sched_if;
    logic       start;
    logic       pause_btn;
    logic       game_over;
    logic       score_inc;
    logic       clk_game;
    logic [1:0] clk_rate;
    logic       tick;
    logic       level_up;
    logic [1:0] state;

    modport master (
        output start, pause_btn, game_over, score_inc, clk_game,
        input  clk_rate, tick, level_up, state
    );

    modport slave (
        input  start, pause_btn, game_over, score_inc, clk_game,
        output clk_rate, tick, level_up, state
    );
endinterface

// File: rtl/game_tick_sched.sv
// Game-state FSM and speed scheduler: derives clk_rate from the score-driven level and
// turns clk_game rises into one-clk tick enables that only fire while running.
module game_tick_sched #(
    parameter int unsigned PTS_PER_LEVEL = 8,
    parameter int unsigned MAX_LEVEL     = 3
) (
    input logic              clk,
    input logic              rst_n,
    game_tick_sched_if.slave bus
);

    localparam int unsigned     PtsW    = $clog2(PTS_PER_LEVEL);
    localparam logic [PtsW-1:0] PtsLast = PtsW'(PTS_PER_LEVEL - 1);
    localparam logic [1:0]      MaxLvl  = 2'(MAX_LEVEL);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StOver  = 2'b11
    } state_e;

    state_e          state_q;
    logic [1:0]      level_q;
    logic [1:0]      clk_rate_q;
    logic [PtsW-1:0] pts_q;
    logic            cg_q;
    logic            tick_q;
    logic            level_up_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            level_q    <= '0;
            clk_rate_q <= '0;
            pts_q      <= '0;
            cg_q       <= 1'b0;
            tick_q     <= 1'b0;
            level_up_q <= 1'b0;
        end else begin
            cg_q       <= bus.clk_game;
            // Uses the pre-transition state, so a rise sampled on the RUN-entry clk is dropped.
            tick_q     <= (state_q == StRun) & bus.clk_game & ~cg_q;
            clk_rate_q <= level_q;
            level_up_q <= 1'b0;

            unique case (state_q)
                StIdle, StOver: begin
                    if (bus.start && !bus.game_over) begin
                        state_q <= StRun;
                        level_q <= '0;
                        pts_q   <= '0;
                    end
                end
                StRun: begin
                    if (bus.game_over) begin
                        state_q <= StOver;
                    end else if (bus.pause_btn) begin
                        state_q <= StPause;
                    end else if (bus.score_inc) begin
                        if (pts_q == PtsLast) begin
                            pts_q <= '0;
                            if (level_q < MaxLvl) begin
                                level_q    <= level_q + 2'd1;
                                level_up_q <= 1'b1;
                            end
                        end else begin
                            pts_q <= pts_q + PtsW'(1);
                        end
                    end
                end
                StPause: begin
                    if (bus.game_over) begin
                        state_q <= StOver;
                    end else if (bus.pause_btn) begin
                        state_q <= StRun;
                    end
                end
            endcase
        end
    end

    assign bus.state    = state_q;
    assign bus.clk_rate = clk_rate_q;
    assign bus.tick     = tick_q;
    assign bus.level_up = level_up_q;

endmodule

// File: tb/tb_game_tick_sched.sv
// Bench for game_tick_sched: directed vector table, hand sequences for multi-cycle corners,
// and randomized traffic checked against a points-counting reference model.
module tb_game_tick_sched;

    localparam int P    = 8;
    localparam int MAXL = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    game_tick_sched_if bus ();

    game_tick_sched #(
        .PTS_PER_LEVEL(P),
        .MAX_LEVEL    (MAXL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic       start, pause, go, inc, cg;
        logic [1:0] st;
        logic       tick, lu;
        logic [1:0] rate;
    } vec_t;

    vec_t tbl[16];

    // Reference model: the game is tracked as total points since the last (re)start.
    int   m_st;
    int   total;
    logic m_cg, m_tick, m_lu;
    int   m_rate;

    function automatic int lvl();
        return (total / P > MAXL) ? MAXL : total / P;
    endfunction

    task automatic model_reset();
        m_st = 0; total = 0; m_cg = 0; m_tick = 0; m_lu = 0; m_rate = 0;
    endtask

    task automatic model_step(input logic s, p, g, i, c);
        m_tick = (m_st == 1) && c && !m_cg;
        m_rate = lvl();
        m_lu   = 1'b0;
        m_cg   = c;
        case (m_st)
            0, 3: if (s && !g) begin m_st = 1; total = 0; end
            1: begin
                if (g) m_st = 3;
                else if (p) m_st = 2;
                else if (i) begin
                    total++;
                    if (total % P == 0 && total / P <= MAXL) m_lu = 1'b1;
                end
            end
            2: if (g) m_st = 3; else if (p) m_st = 1;
            default: ;
        endcase
    endtask

    function automatic logic [5:0] dut_out();
        return {bus.state, bus.clk_rate, bus.tick, bus.level_up};
    endfunction

    function automatic logic [5:0] model_out();
        return {2'(m_st), 2'(m_rate), m_tick, m_lu};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic s, p, g, i, c);
        bus.start = s; bus.pause_btn = p; bus.game_over = g; bus.score_inc = i;
        bus.clk_game = c;
        @(posedge clk);
        #1;
        model_step(s, p, g, i, c);
    endtask

    task automatic apply(input logic s, p, g, i, c);
        drive(s, p, g, i, c);
        check("model", {2'b0, dut_out()}, {2'b0, model_out()});
    endtask

    task automatic reset_seq();
        rst_n = 1'b0;
        bus.start = 0; bus.pause_btn = 0; bus.game_over = 0; bus.score_inc = 0;
        bus.clk_game = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int n, bad, lu_seen, cnt, hp;
        logic cgv, gov;

        //        st pa go in cg | state tick lu rate
        tbl[0]  = '{0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0};
        tbl[1]  = '{1, 0, 0, 0, 1, 2'd1, 0, 0, 2'd0}; // rise on RUN-entry clk dropped
        tbl[2]  = '{0, 0, 0, 0, 1, 2'd1, 0, 0, 2'd0};
        tbl[3]  = '{0, 0, 0, 0, 0, 2'd1, 0, 0, 2'd0};
        tbl[4]  = '{0, 0, 0, 0, 1, 2'd1, 1, 0, 2'd0};
        tbl[5]  = '{0, 0, 0, 1, 1, 2'd1, 0, 0, 2'd0};
        tbl[6]  = '{0, 1, 0, 1, 0, 2'd2, 0, 0, 2'd0};
        tbl[7]  = '{0, 0, 0, 0, 1, 2'd2, 0, 0, 2'd0};
        tbl[8]  = '{0, 0, 0, 1, 1, 2'd2, 0, 0, 2'd0};
        tbl[9]  = '{0, 1, 0, 0, 0, 2'd1, 0, 0, 2'd0};
        tbl[10] = '{0, 0, 0, 0, 1, 2'd1, 1, 0, 2'd0};
        tbl[11] = '{0, 1, 1, 1, 0, 2'd3, 0, 0, 2'd0};
        tbl[12] = '{1, 0, 1, 0, 0, 2'd3, 0, 0, 2'd0};
        tbl[13] = '{1, 0, 0, 0, 0, 2'd1, 0, 0, 2'd0};
        tbl[14] = '{1, 1, 0, 0, 0, 2'd2, 0, 0, 2'd0};
        tbl[15] = '{0, 1, 0, 0, 0, 2'd1, 0, 0, 2'd0};

        reset_seq();
        check("reset_state", {2'b0, dut_out()}, 8'h00);

        for (int k = 0; k < 16; k++) begin
            drive(tbl[k].start, tbl[k].pause, tbl[k].go, tbl[k].inc, tbl[k].cg);
            check($sformatf("table[%0d]", k), {2'b0, dut_out()},
                  {2'b0, tbl[k].st, tbl[k].rate, tbl[k].tick, tbl[k].lu});
        end

        // Leveling, with a pause/score collision on the 8th point.
        repeat (7) apply(0, 0, 0, 1, 0);
        apply(0, 1, 0, 1, 0);
        check("collision_pause", {6'b0, bus.state}, 8'd2);
        apply(0, 1, 0, 0, 0);
        apply(0, 0, 0, 1, 0);
        check("level_up_pulse", {6'b0, bus.clk_rate, bus.level_up}, {6'b0, 2'd0, 1'b1});
        apply(0, 0, 0, 0, 0);
        check("rate_follows", {6'b0, bus.clk_rate, bus.level_up}, {6'b0, 2'd1, 1'b0});
        repeat (16) apply(0, 0, 0, 1, 0);
        apply(0, 0, 0, 0, 0);
        check("rate_max", {6'b0, bus.clk_rate}, 8'd3);
        lu_seen = 0;
        for (int k = 0; k < 8; k++) begin
            apply(0, 0, 0, 1, 0);
            if (bus.level_up) lu_seen++;
        end
        apply(0, 0, 0, 0, 0);
        check("max_no_level_up", 8'(lu_seen), 8'd0);
        check("max_rate_holds", {6'b0, bus.clk_rate}, 8'd3);

        // Game over and restart.
        apply(0, 0, 1, 0, 0);
        check("over", {6'b0, bus.state}, 8'd3);
        apply(0, 0, 1, 1, 0);
        check("over_rate_held", {6'b0, bus.clk_rate}, 8'd3);
        apply(1, 0, 1, 0, 0);
        check("start_blocked", {6'b0, bus.state}, 8'd3);
        apply(0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0);
        check("restart_run", {6'b0, bus.state}, 8'd1);
        apply(0, 0, 0, 0, 0);
        check("restart_rate", {6'b0, bus.clk_rate}, 8'd0);
        repeat (7) apply(0, 0, 0, 1, 0);
        check("restart_pts_7", {7'b0, bus.level_up}, 8'd0);
        apply(0, 0, 0, 1, 0);
        check("restart_pts_8", {7'b0, bus.level_up}, 8'd1);
        repeat (8) apply(0, 0, 0, 1, 0);
        apply(0, 0, 0, 0, 0);
        check("pre_reset_level", {6'b0, bus.clk_rate}, 8'd2);

        // Asynchronous reset mid-cycle, observed before any clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", {2'b0, dut_out()}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        apply(1, 1, 0, 0, 0);
        check("idle_start_pause", {6'b0, bus.state}, 8'd1);

        // Ticks from a period-16 clk_game.
        n = 0; bad = 0;
        for (int c = 0; c < 64; c++) begin
            apply(0, 0, 0, 0, (c % 16) >= 8);
            if (bus.tick) begin
                n++;
                if (c % 16 != 8) bad++;
            end
        end
        check("ticks_per_period", 8'(n), 8'd4);
        check("tick_phase", 8'(bad), 8'd0);

        apply(0, 1, 0, 0, 0);
        n = 0;
        for (int c = 0; c < 48; c++) begin
            apply(0, 0, 0, (c % 16) == 3, (c % 16) >= 8);
            if (bus.tick) n++;
        end
        check("pause_no_tick", 8'(n), 8'd0);
        apply(0, 1, 0, 0, 0);
        n = 0;
        for (int c = 0; c < 16; c++) begin
            apply(0, 0, 0, 0, (c % 16) >= 8);
            if (bus.tick) n++;
        end
        check("resume_tick", 8'(n), 8'd1);

        // Randomized traffic against the model.
        cnt = 0; hp = 4; cgv = 0; gov = 0;
        for (int c = 0; c < 3000; c++) begin
            if (++cnt >= hp) begin
                cnt = 0;
                cgv = ~cgv;
                hp  = $urandom_range(1, 8);
            end
            if ($urandom_range(0, 59) == 0) gov = ~gov;
            apply($urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0, gov,
                  $urandom_range(0, 2) == 0, cgv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
